// File: rtl/id_stage_param_if.sv
// Fetch/write-back to decode/execute bundle for the parameterised ID stage.
// The master drives IF/ID and write-back inputs; the slave (ID stage) drives the DX boundary and stall.
interface id_stage_param_if #(
    parameter int DATA_W  = 32,
    parameter int REG_NUM = 32
);
    localparam int ADDR_W = $clog2(REG_NUM);

    logic              fd_valid;
    logic [31:0]       IR;
    logic [DATA_W-1:0] PC;
    logic              flush;
    logic              hold;
    logic              MW_we;
    logic [ADDR_W-1:0] MW_RD;
    logic [DATA_W-1:0] MW_data;

    logic              stall;
    logic              DX_valid;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic [DATA_W-1:0] DX_immediate;
    logic [ADDR_W-1:0] RD;
    logic [2:0]        ALUctr;
    logic              DX_lwFlag;
    logic              DX_swFlag;
    logic [2:0]        DX_compareFlag;
    logic [DATA_W-1:0] DX_PC;
    logic              DX_illegal;

    modport master (
        output fd_valid, IR, PC, flush, hold, MW_we, MW_RD, MW_data,
        input  stall, DX_valid, A, B, DX_immediate, RD, ALUctr,
               DX_lwFlag, DX_swFlag, DX_compareFlag, DX_PC, DX_illegal
    );

    modport slave (
        input  fd_valid, IR, PC, flush, hold, MW_we, MW_RD, MW_data,
        output stall, DX_valid, A, B, DX_immediate, RD, ALUctr,
               DX_lwFlag, DX_swFlag, DX_compareFlag, DX_PC, DX_illegal
    );
endinterface

// File: rtl/id_stage_param.sv
// Parameterised MIPS instruction-decode stage: register file with write bypass,
// R/I/J decode, load-use stall, hold/flush handling and a registered DX boundary.
module id_stage_param #(
    parameter int DATA_W  = 32,
    parameter int REG_NUM = 32
) (
    input logic          clk,
    input logic          rst,
    id_stage_param_if.slave bus
);
    localparam int ADDR_W = $clog2(REG_NUM);

    // Immediate forming helpers.
    function automatic logic signed [DATA_W-1:0] sext16(input logic [15:0] v);
        return {{(DATA_W-16){v[15]}}, v};
    endfunction

    function automatic logic [DATA_W-1:0] zext26(input logic [25:0] v);
        return {{(DATA_W-26){1'b0}}, v};
    endfunction

    logic [DATA_W-1:0] regs_q [REG_NUM];

    logic [5:0]        op;
    logic [5:0]        funct;
    logic [ADDR_W-1:0] rs_f, rt_f, rd_f;
    logic [DATA_W-1:0] rs_val, rt_val;
    logic              unused_ir;

    // Shamt and unused register-field bits carry no meaning for this stage.
    assign unused_ir = ^bus.IR;
    assign op    = bus.IR[31:26];
    assign funct = bus.IR[5:0];
    assign rs_f  = bus.IR[21 +: ADDR_W];
    assign rt_f  = bus.IR[16 +: ADDR_W];
    assign rd_f  = bus.IR[11 +: ADDR_W];

    // Decoded fields, before the DX register.
    logic signed [DATA_W-1:0] dec_a, dec_b, dec_imm;
    logic [ADDR_W-1:0]        dec_rd;
    logic [2:0]               dec_alu, dec_cmp;
    logic                     dec_lw, dec_sw, dec_ill, reads_rt;

    // DX boundary registers.
    logic                     dx_valid_q, dx_valid_d;
    logic signed [DATA_W-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
    logic [DATA_W-1:0]        pc_q, pc_d;
    logic [ADDR_W-1:0]        rd_q, rd_d;
    logic [2:0]               alu_q, alu_d, cmp_q, cmp_d;
    logic                     lw_q, lw_d, sw_q, sw_d, ill_q, ill_d;
    logic                     load_use;

    // Register file: r0 is never written, write-back lands on the rising edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
        end else if (bus.MW_we && bus.MW_RD != '0) begin
            regs_q[bus.MW_RD] <= bus.MW_data;
        end
    end

    // Source reads, with write-back data forwarded when it targets the same register.
    always_comb begin
        rs_val = '0;
        rt_val = '0;
        if (rs_f != '0) rs_val = (bus.MW_we && bus.MW_RD == rs_f) ? bus.MW_data : regs_q[rs_f];
        if (rt_f != '0) rt_val = (bus.MW_we && bus.MW_RD == rt_f) ? bus.MW_data : regs_q[rt_f];
    end

    // Instruction decode; unsupported encodings zero every field except the illegal flag.
    always_comb begin
        dec_a    = '0;
        dec_b    = '0;
        dec_imm  = '0;
        dec_rd   = '0;
        dec_alu  = 3'd0;
        dec_cmp  = 3'd0;
        dec_lw   = 1'b0;
        dec_sw   = 1'b0;
        dec_ill  = 1'b0;
        reads_rt = 1'b0;
        case (op)
            6'd0: begin
                reads_rt = 1'b1;
                dec_a    = rs_val;
                dec_b    = rt_val;
                dec_rd   = rd_f;
                case (funct)
                    6'd32:   dec_alu = 3'd0;
                    6'd34:   dec_alu = 3'd1;
                    6'd42:   dec_alu = 3'd2;
                    6'd36:   dec_alu = 3'd3;
                    6'd37:   dec_alu = 3'd4;
                    default: dec_ill = 1'b1;
                endcase
            end
            6'd35: begin
                dec_a  = rs_val;
                dec_b  = sext16(bus.IR[15:0]);
                dec_rd = rt_f;
                dec_lw = 1'b1;
            end
            6'd43: begin
                reads_rt = 1'b1;
                dec_a    = rs_val;
                dec_b    = sext16(bus.IR[15:0]);
                dec_imm  = rt_val;
                dec_sw   = 1'b1;
            end
            6'd8: begin
                dec_a  = rs_val;
                dec_b  = sext16(bus.IR[15:0]);
                dec_rd = rt_f;
            end
            6'd4, 6'd5: begin
                reads_rt = 1'b1;
                dec_a    = rs_val;
                dec_b    = rt_val;
                dec_imm  = sext16(bus.IR[15:0]);
                dec_alu  = 3'd2;
                dec_cmp  = (op == 6'd4) ? 3'd1 : 3'd3;
            end
            6'd2: begin
                dec_b   = zext26(bus.IR[25:0]);
                dec_alu = 3'd2;
                dec_cmp = 3'd2;
            end
            default: dec_ill = 1'b1;
        endcase
        if (dec_ill) begin
            dec_a   = '0;
            dec_b   = '0;
            dec_imm = '0;
            dec_rd  = '0;
            dec_alu = 3'd0;
        end
    end

    assign load_use = dx_valid_q && lw_q && (rd_q != '0) &&
                      ((rd_q == rs_f) || (reads_rt && rd_q == rt_f));
    assign bus.stall = (bus.fd_valid && load_use) || bus.hold;

    // DX next state: flush beats hold; hold freezes; otherwise load or insert a bubble.
    always_comb begin
        dx_valid_d = dx_valid_q;
        a_d        = a_q;
        b_d        = b_q;
        imm_d      = imm_q;
        pc_d       = pc_q;
        rd_d       = rd_q;
        alu_d      = alu_q;
        cmp_d      = cmp_q;
        lw_d       = lw_q;
        sw_d       = sw_q;
        ill_d      = ill_q;
        if (bus.flush || !bus.hold) begin
            a_d        = dec_a;
            b_d        = dec_b;
            imm_d      = dec_imm;
            pc_d       = bus.PC;
            dx_valid_d = 1'b0;
            rd_d       = '0;
            alu_d      = 3'd0;
            cmp_d      = 3'd0;
            lw_d       = 1'b0;
            sw_d       = 1'b0;
            ill_d      = 1'b0;
            if (!bus.flush && !load_use && bus.fd_valid) begin
                dx_valid_d = !dec_ill;
                rd_d       = dec_rd;
                alu_d      = dec_alu;
                cmp_d      = dec_cmp;
                lw_d       = dec_lw;
                sw_d       = dec_sw;
                ill_d      = dec_ill;
            end
        end
    end

    // DX register; reset discards in-flight contents immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dx_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            imm_q      <= '0;
            pc_q       <= '0;
            rd_q       <= '0;
            alu_q      <= 3'd0;
            cmp_q      <= 3'd0;
            lw_q       <= 1'b0;
            sw_q       <= 1'b0;
            ill_q      <= 1'b0;
        end else begin
            dx_valid_q <= dx_valid_d;
            a_q        <= a_d;
            b_q        <= b_d;
            imm_q      <= imm_d;
            pc_q       <= pc_d;
            rd_q       <= rd_d;
            alu_q      <= alu_d;
            cmp_q      <= cmp_d;
            lw_q       <= lw_d;
            sw_q       <= sw_d;
            ill_q      <= ill_d;
        end
    end

    assign bus.DX_valid       = dx_valid_q;
    assign bus.A              = a_q;
    assign bus.B              = b_q;
    assign bus.DX_immediate   = imm_q;
    assign bus.DX_PC          = pc_q;
    assign bus.RD             = rd_q;
    assign bus.ALUctr         = alu_q;
    assign bus.DX_compareFlag = cmp_q;
    assign bus.DX_lwFlag      = lw_q;
    assign bus.DX_swFlag      = sw_q;
    assign bus.DX_illegal     = ill_q;
endmodule

// File: tb/tb_id_stage_param.sv
// Directed bench for id_stage_param: a 32-bit/32-register instance and a
// 64-bit/8-register instance driven with the same instruction stream.
module tb_id_stage_param;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    id_stage_param_if #(.DATA_W(32), .REG_NUM(32)) b32 ();
    id_stage_param_if #(.DATA_W(64), .REG_NUM(8))  b64 ();

    id_stage_param #(.DATA_W(32), .REG_NUM(32)) u_dut32 (.clk(clk), .rst(rst), .bus(b32));
    id_stage_param #(.DATA_W(64), .REG_NUM(8))  u_dut64 (.clk(clk), .rst(rst), .bus(b64));

    assign b64.fd_valid = b32.fd_valid;
    assign b64.IR       = b32.IR;
    assign b64.PC       = {32'd0, b32.PC};
    assign b64.flush    = b32.flush;
    assign b64.hold     = b32.hold;
    assign b64.MW_we    = b32.MW_we;
    assign b64.MW_RD    = b32.MW_RD[2:0];
    assign b64.MW_data  = {32'd0, b32.MW_data};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction

    function automatic logic [31:0] itype(input int op, input int rs, input int rt, input logic [15:0] imm);
        return {6'(op), 5'(rs), 5'(rt), imm};
    endfunction

    initial begin
        b32.fd_valid = 1'b0;
        b32.IR       = '0;
        b32.PC       = '0;
        b32.flush    = 1'b0;
        b32.hold     = 1'b0;
        b32.MW_we    = 1'b0;
        b32.MW_RD    = '0;
        b32.MW_data  = '0;
        #12;
        chk("rst_valid", b32.DX_valid, 0);
        chk("rst_pc", b32.DX_PC, 0);
        chk("rst_A", b32.A, 0);
        chk("rst_ill", b32.DX_illegal, 0);
        @(negedge clk);
        rst = 1'b1;

        // Preload r1=5, r2=7 through write-back
        b32.MW_we = 1'b1; b32.MW_RD = 5'd1; b32.MW_data = 32'd5;
        step();
        b32.MW_RD = 5'd2; b32.MW_data = 32'd7;
        step();
        b32.MW_we = 1'b0;

        // add r3,r1,r2
        b32.fd_valid = 1'b1; b32.IR = rtype(1, 2, 3, 32); b32.PC = 32'h100;
        step();
        chk("add_valid", b32.DX_valid, 1);
        chk("add_A", b32.A, 5);
        chk("add_B", b32.B, 7);
        chk("add_RD", b32.RD, 3);
        chk("add_alu", b32.ALUctr, 0);
        chk("add_pc", b32.DX_PC, 32'h100);
        chk("add_A64", b64.A, 5);

        // lw r4,-8(r1)
        b32.IR = itype(35, 1, 4, 16'hFFF8); b32.PC = 32'h104;
        step();
        chk("lw_B32", b32.B, 32'hFFFF_FFF8);
        chk("lw_B64", b64.B, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("lw_RD", b32.RD, 4);
        chk("lw_flag", b32.DX_lwFlag, 1);
        chk("lw_A", b32.A, 5);

        // add r5,r4,r2 right behind the load
        b32.IR = rtype(4, 2, 5, 32); b32.PC = 32'h108;
        #1;
        chk("lu_stall", b32.stall, 1);
        step();
        chk("lu_bubble_valid", b32.DX_valid, 0);
        chk("lu_bubble_RD", b32.RD, 0);
        chk("lu_bubble_lw", b32.DX_lwFlag, 0);
        chk("lu_stall_drop", b32.stall, 0);
        step();
        chk("lu_issue_valid", b32.DX_valid, 1);
        chk("lu_issue_RD", b32.RD, 5);
        chk("lu_issue_B", b32.B, 7);

        // sub r6,r2,r0 with concurrent write-back of r2
        b32.MW_we = 1'b1; b32.MW_RD = 5'd2; b32.MW_data = 32'hAB;
        b32.IR = rtype(2, 0, 6, 34);
        step();
        chk("byp_A", b32.A, 32'hAB);
        chk("byp_B", b32.B, 0);
        chk("byp_alu", b32.ALUctr, 1);
        chk("byp_RD", b32.RD, 6);
        chk("byp_A64", b64.A, 64'hAB);

        // attempted write to r0
        b32.MW_RD = 5'd0; b32.MW_data = 32'h55;
        b32.IR = rtype(0, 0, 7, 32);
        step();
        chk("r0_byp_A", b32.A, 0);
        b32.MW_we = 1'b0;
        b32.IR = rtype(0, 2, 7, 32);
        step();
        chk("r0_A", b32.A, 0);
        chk("r0_A64", b64.A, 0);
        chk("r2_B", b32.B, 32'hAB);

        // beq r1,r2,-1 flushed
        b32.IR = itype(4, 1, 2, 16'hFFFF); b32.flush = 1'b1;
        step();
        chk("flush_valid", b32.DX_valid, 0);
        chk("flush_cmp", b32.DX_compareFlag, 0);
        b32.flush = 1'b0;
        step();
        chk("beq_valid", b32.DX_valid, 1);
        chk("beq_cmp", b32.DX_compareFlag, 1);
        chk("beq_alu", b32.ALUctr, 2);
        chk("beq_A", b32.A, 5);
        chk("beq_B", b32.B, 32'hAB);
        chk("beq_imm", b32.DX_immediate, 32'hFFFF_FFFF);
        chk("beq_RD", b32.RD, 0);

        // hold for 3 cycles with new IRs arriving
        b32.hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b32.IR = (i == 2) ? itype(8, 1, 3, 16'd12) : rtype(1, 2, 5 + i, 37);
            #1;
            chk("hold_stall", b32.stall, 1);
            step();
            chk("hold_cmp", b32.DX_compareFlag, 1);
            chk("hold_A", b32.A, 5);
            chk("hold_valid", b32.DX_valid, 1);
        end
        b32.hold = 1'b0;
        step();
        chk("addi_valid", b32.DX_valid, 1);
        chk("addi_A", b32.A, 5);
        chk("addi_B", b32.B, 12);
        chk("addi_RD", b32.RD, 3);
        chk("addi_cmp", b32.DX_compareFlag, 0);

        // flush together with hold
        b32.hold = 1'b1; b32.flush = 1'b1;
        step();
        chk("fh_valid", b32.DX_valid, 0);
        chk("fh_RD", b32.RD, 0);
        b32.hold = 1'b0; b32.flush = 1'b0;

        // j 0x123
        b32.IR = {6'd2, 26'h123};
        step();
        chk("j_B", b32.B, 32'h123);
        chk("j_cmp", b32.DX_compareFlag, 2);
        chk("j_alu", b32.ALUctr, 2);
        chk("j_A", b32.A, 0);

        // illegal opcode, then cleared by a bubble
        b32.IR = {6'd63, 26'd0};
        step();
        chk("ill_flag", b32.DX_illegal, 1);
        chk("ill_valid", b32.DX_valid, 0);
        b32.fd_valid = 1'b0;
        step();
        chk("ill_clear", b32.DX_illegal, 0);

        // sw r2,4(r1)
        b32.fd_valid = 1'b1; b32.IR = itype(43, 1, 2, 16'd4);
        step();
        chk("sw_flag", b32.DX_swFlag, 1);
        chk("sw_imm", b32.DX_immediate, 32'hAB);
        chk("sw_B", b32.B, 4);
        chk("sw_RD", b32.RD, 0);

        // asynchronous reset mid-stream
        b32.IR = rtype(1, 2, 3, 32); b32.PC = 32'h200;
        step();
        chk("pre_rst_valid", b32.DX_valid, 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", b32.DX_valid, 0);
        chk("arst_A", b32.A, 0);
        chk("arst_pc", b32.DX_PC, 0);
        chk("arst_RD", b32.RD, 0);
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("post_rst_valid", b32.DX_valid, 1);
        chk("post_rst_A", b32.A, 0);
        chk("post_rst_B", b32.B, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/id_stage_param.md
# id_stage_param

Parametrised instruction-decode pipeline stage for the five-stage MIPS core, sitting between fetch (IF/ID) and execute (DX). It holds the register file, decodes R/I/J instructions into ALU control, operands and flags, and registers them into the DX boundary with one cycle of latency. It adds the following over the fixed 32-bit decoder:
- valid tracking;
- write-to-read bypass;
- load-use hazard stall;
- downstream hold;
- branch flush;
- illegal-instruction flagging.

## Interface
- DATA_W, 32, datapath width; legal range 32..64.
- REG_NUM, 32, register count; a power of two, 8..32. ADDR_W = log2(REG_NUM). Register fields use the low ADDR_W bits of IR[25:21], IR[20:16] and IR[15:11].

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- fd_valid  input  1  IR/PC hold a real instruction
- IR  input  32  instruction word
- PC  input  DATA_W  PC of the instruction
- flush  input  1  kill the instruction entering DX this edge (taken branch or jump)
- hold  input  1  EX is stalled; DX outputs must freeze
- MW_we  input  1  write-back enable
- MW_RD  input  ADDR_W  write-back register index
- MW_data  input  DATA_W  write-back data
- stall  output  1  combinational; IF must hold IR/PC this cycle
- DX_valid  output  1  DX contents are a real instruction
- A, B  output  DATA_W  operand A; operand B or immediate
- DX_immediate  output  DATA_W  branch offset, or store data for sw
- RD  output  ADDR_W  destination register; 0 means none
- ALUctr  output  3  0 add, 1 sub, 2 slt/compare, 3 and, 4 or
- DX_lwFlag, DX_swFlag  output  1  load / store
- DX_compareFlag  output  3  0 none, 1 beq, 2 j, 3 bne
- DX_PC  output  DATA_W  PC passed through
- DX_illegal  output  1  the decoded opcode/funct was unsupported

## Operation

**Register file**
- REG_NUM × DATA_W entries, written on posedge when MW_we=1 and MW_RD≠0.
- Register 0 always reads 0.
- rst=0 clears all entries.

**Read bypass**
- When MW_we=1, MW_RD equals a source index, and that index ≠ 0, the read returns MW_data instead of the array value.

**Decode (fd_valid=1)**
- R-type, op 0:
  - funct 32 add (ALUctr 0), 34 sub (1), 42 slt (2), 36 and (3), 37 or (4).
  - A=rs, B=rt, RD=rd.
- lw, op 35: A=rs, B=sext(imm16), RD=rt, ALUctr 0, DX_lwFlag=1.
- sw, op 43: A=rs, B=sext(imm16), DX_immediate=rt value, RD=0, ALUctr 0, DX_swFlag=1.
- addi, op 8: A=rs, B=sext(imm16), RD=rt, ALUctr 0.
- beq, op 4 / bne, op 5: A=rs, B=rt, DX_immediate=sext(imm16), RD=0, ALUctr 2, compare flag 1 or 3.
- j, op 2: B=zext(IR[25:0]), RD=0, ALUctr 2, compare flag 2.
- Sign extension replicates IR[15] up to DATA_W.
- Fields not listed for an instruction are driven to 0.
- Any other opcode/funct:
  - DX_valid=0, DX_illegal=1, all other control fields 0.
  - DX_illegal is cleared by the next loaded instruction or bubble.

**Hazards**
- load_use = DX_valid & DX_lwFlag & RD≠0 & (RD==rs | (RD==rt & instruction reads rt)).
- Instructions that read rt: R-type, sw, beq, bne.
- stall = fd_valid & load_use, or hold.

**Per-edge priority (highest first)**
1. flush → bubble.
2. hold → all DX registers keep their values.
3. load_use → bubble.
4. fd_valid=0 → bubble.
5. Otherwise load the decoded instruction.

- Bubble: DX_valid=0, RD=0, all flags, ALUctr and DX_illegal = 0. A, B, DX_immediate and DX_PC are don't-care; they are loaded as in a normal decode.

## Timing
- All DX outputs are registered; latency IR→DX is 1 cycle.
- stall is combinational from the current IR and the DX registers.
- Asynchronous reset (rst low): all DX outputs 0, including DX_PC, DX_valid and DX_illegal. Register file cleared.
- Reset asserted mid-operation discards the in-flight DX contents immediately.
- The first load after rst deasserts happens on the next edge.
- A write and a read of the same register in the same cycle return the new data (bypass); the array updates on the same edge.
- flush together with hold: the bubble wins, and DX_valid goes 0 even though EX is held.
- Load-use costs exactly one bubble. The following cycle re-evaluates with DX_valid=0, so stall drops.

## Test plan
- Reset, then add r3,r1,r2 with r1=5, r2=7 preloaded via write-back → 1 cycle later: DX_valid=1, A=5, B=7, RD=3, ALUctr=0.
- lw r4,-8(r1) → B=all-ones…FFF8 at DATA_W=32 and 64, RD=4, DX_lwFlag=1. Next IR add r5,r4,r2: stall=1 for 1 cycle, one bubble, then the add issues.
- MW_we=1, MW_RD=2, MW_data=0xAB, in the same cycle as sub r6,r2,r0 → B=0 (r0 reads 0), A=0xAB. Attempted write to r0 → r0 still reads 0.
- beq r1,r2,-1 with flush=1 on that edge → DX_valid=0, DX_compareFlag=0.
- hold=1 for 3 cycles while new IRs arrive → DX outputs unchanged and stall=1. Release → the held IR decodes.
- opcode 63 → DX_illegal=1, DX_valid=0. rst pulsed low mid-stream → all outputs 0 asynchronously.
